// File: rtl/layer_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM encoding and default port widths.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOST   = 2'd3
  } state_e;

  localparam int DEF_N_LAYER = 8;
  localparam int DEF_RAM_AW  = 16;
  localparam int DEF_RAM_DW  = 8;
  localparam int DEF_ROMW_AW = 15;
  localparam int DEF_ROMO_AW = 9;
  localparam int DEF_TMO_W   = 24;

endpackage

// File: rtl/layer_seq_mux_next_sel.sv
// Finds the lowest enabled layer strictly above cur_i, or the lowest enabled layer
// at all when first_i is set (the "cur_layer = -1" case used when a run starts).
module lyr_next_sel
  import layer_seq_pkg::*;
#(
  parameter int N_LAYER = DEF_N_LAYER,
  parameter int LW      = $clog2(N_LAYER)
) (
  input  logic [N_LAYER-1:0] mask_i,
  input  logic [LW-1:0]      cur_i,
  input  logic               first_i,
  output logic [LW-1:0]      nxt_o,
  output logic               vld_o
);

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    nxt_o = '0;
    vld_o = 1'b0;
    for (int i = N_LAYER - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
        nxt_o = LW'(i);
        vld_o = 1'b1;
      end else begin
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/layer_seq_mux.sv
// Layer sequencer and shared memory-port arbiter: launches masked layer engines in
// index order, routes the active engine onto the shared RAM/ROM ports, guards each layer with a watchdog.
module layer_seq_mux
  import layer_seq_pkg::*;
#(
  parameter int N_LAYER = DEF_N_LAYER,
  parameter int RAM_AW  = DEF_RAM_AW,
  parameter int RAM_DW  = DEF_RAM_DW,
  parameter int ROMW_AW = DEF_ROMW_AW,
  parameter int ROMO_AW = DEF_ROMO_AW,
  parameter int TMO_W   = DEF_TMO_W,
  parameter int LW      = $clog2(N_LAYER)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_LAYER-1:0]         layer_en,
  input  logic [TMO_W-1:0]           tmo_limit,
  output logic [N_LAYER-1:0]         lyr_start,
  input  logic [N_LAYER-1:0]         lyr_done,
  input  logic [N_LAYER*RAM_AW-1:0]  lyr_ram_waddr,
  input  logic [N_LAYER*RAM_DW-1:0]  lyr_ram_wdata,
  input  logic [N_LAYER-1:0]         lyr_ram_en,
  input  logic [N_LAYER-1:0]         lyr_ram_we,
  input  logic [N_LAYER*RAM_AW-1:0]  lyr_ram_raddr,
  input  logic [N_LAYER-1:0]         lyr_ram_ren,
  input  logic [N_LAYER*ROMW_AW-1:0] lyr_romw_addr,
  input  logic [N_LAYER-1:0]         lyr_romw_en,
  input  logic [N_LAYER*ROMO_AW-1:0] lyr_romo_addr,
  input  logic [N_LAYER-1:0]         lyr_romo_en,
  input  logic [RAM_AW-1:0]          host_raddr,
  input  logic                       host_ren,
  output logic [RAM_AW-1:0]          ram_waddr,
  output logic [RAM_DW-1:0]          ram_wdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [RAM_AW-1:0]          ram_raddr,
  output logic                       ram_ren,
  output logic [ROMW_AW-1:0]         romw_addr,
  output logic                       romw_en,
  output logic [ROMO_AW-1:0]         romo_addr,
  output logic                       romo_en,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic [LW-1:0]              cur_layer
);

  localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  state_e             state_q;
  logic [N_LAYER-1:0] mask_q;
  logic [LW-1:0]      cur_q;
  logic [TMO_W-1:0]   wdog_q;
  logic [N_LAYER-1:0] lyr_start_q;
  logic               busy_q;
  logic               done_q;
  logic               tmo_q;

  logic               arm_s;
  logic [LW-1:0]      nxt_s;
  logic               nxt_vld_s;
  int                 sl_s;

  function automatic logic [N_LAYER-1:0] onehot(input logic [LW-1:0] idx);
    logic [N_LAYER-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // While idle the selector looks at the live layer_en so the first layer is known on the start edge.
  assign arm_s = (state_q == ST_IDLE) || (state_q == ST_HOST);

  lyr_next_sel #(
    .N_LAYER (N_LAYER),
    .LW      (LW)
  ) u_next_sel (
    .mask_i  (arm_s ? layer_en : mask_q),
    .cur_i   (cur_q),
    .first_i (arm_s),
    .nxt_o   (nxt_s),
    .vld_o   (nxt_vld_s)
  );

  // Sequencer FSM, watchdog and registered status/start outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      cur_q       <= '0;
      wdog_q      <= '0;
      lyr_start_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      lyr_start_q <= '0;
      case (state_q)
        ST_IDLE, ST_HOST: begin
          if (start) begin
            mask_q <= layer_en;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            if (nxt_vld_s) begin
              cur_q       <= nxt_s;
              lyr_start_q <= onehot(nxt_s);
              busy_q      <= 1'b1;
              state_q     <= ST_LAUNCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_HOST;
            end
          end else begin
            state_q <= state_q;
          end
        end
        ST_LAUNCH: begin
          wdog_q  <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (lyr_done[cur_q]) begin
            if (nxt_vld_s) begin
              cur_q       <= nxt_s;
              lyr_start_q <= onehot(nxt_s);
              state_q     <= ST_LAUNCH;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_HOST;
            end
          end else if ((tmo_limit != '0) && (wdog_q == (tmo_limit - TMO_ONE))) begin
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_HOST;
          end else begin
            wdog_q <= wdog_q + TMO_ONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sl_s = int'(cur_q);

  // Shared-port routing: active engine in RUN, host read port when idle, quiet otherwise.
  always_comb begin
    ram_waddr = '0;
    ram_wdata = '0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_raddr = '0;
    ram_ren   = 1'b0;
    romw_addr = '0;
    romw_en   = 1'b0;
    romo_addr = '0;
    romo_en   = 1'b0;
    case (state_q)
      ST_RUN: begin
        ram_waddr = lyr_ram_waddr[sl_s*RAM_AW +: RAM_AW];
        ram_wdata = lyr_ram_wdata[sl_s*RAM_DW +: RAM_DW];
        ram_en    = lyr_ram_en[cur_q];
        ram_we    = lyr_ram_we[cur_q];
        ram_raddr = lyr_ram_raddr[sl_s*RAM_AW +: RAM_AW];
        ram_ren   = lyr_ram_ren[cur_q];
        romw_addr = lyr_romw_addr[sl_s*ROMW_AW +: ROMW_AW];
        romw_en   = lyr_romw_en[cur_q];
        romo_addr = lyr_romo_addr[sl_s*ROMO_AW +: ROMO_AW];
        romo_en   = lyr_romo_en[cur_q];
      end
      ST_IDLE, ST_HOST: begin
        ram_raddr = host_raddr;
        ram_ren   = host_ren;
      end
      default: begin
        ram_ren = 1'b0;
      end
    endcase
  end

  assign lyr_start   = lyr_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign cur_layer   = cur_q;

endmodule

// File: tb/tb_layer_seq_mux.sv
// Directed self-checking bench for layer_seq_mux with the default 8-layer configuration.
module tb_layer_seq_mux;

  localparam int NL = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [NL-1:0]   layer_en;
  logic [23:0]     tmo_limit;
  logic [NL-1:0]   lyr_start;
  logic [NL-1:0]   lyr_done;
  logic [NL*16-1:0] lyr_ram_waddr;
  logic [NL*8-1:0]  lyr_ram_wdata;
  logic [NL-1:0]   lyr_ram_en;
  logic [NL-1:0]   lyr_ram_we;
  logic [NL*16-1:0] lyr_ram_raddr;
  logic [NL-1:0]   lyr_ram_ren;
  logic [NL*15-1:0] lyr_romw_addr;
  logic [NL-1:0]   lyr_romw_en;
  logic [NL*9-1:0]  lyr_romo_addr;
  logic [NL-1:0]   lyr_romo_en;
  logic [15:0]     host_raddr;
  logic            host_ren;
  logic [15:0]     ram_waddr;
  logic [7:0]      ram_wdata;
  logic            ram_en;
  logic            ram_we;
  logic [15:0]     ram_raddr;
  logic            ram_ren;
  logic [14:0]     romw_addr;
  logic            romw_en;
  logic [8:0]      romo_addr;
  logic            romo_en;
  logic            busy;
  logic            done;
  logic            timeout_err;
  logic [2:0]      cur_layer;

  logic [15:0] waddr_t [NL];
  logic [7:0]  wdata_t [NL];
  logic [15:0] raddr_t [NL];
  logic [14:0] romw_t  [NL];
  logic [8:0]  romo_t  [NL];

  int n_checks = 0;
  int n_errors = 0;

  layer_seq_mux dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_en(layer_en), .tmo_limit(tmo_limit),
    .lyr_start(lyr_start), .lyr_done(lyr_done),
    .lyr_ram_waddr(lyr_ram_waddr), .lyr_ram_wdata(lyr_ram_wdata),
    .lyr_ram_en(lyr_ram_en), .lyr_ram_we(lyr_ram_we),
    .lyr_ram_raddr(lyr_ram_raddr), .lyr_ram_ren(lyr_ram_ren),
    .lyr_romw_addr(lyr_romw_addr), .lyr_romw_en(lyr_romw_en),
    .lyr_romo_addr(lyr_romo_addr), .lyr_romo_en(lyr_romo_en),
    .host_raddr(host_raddr), .host_ren(host_ren),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren),
    .romw_addr(romw_addr), .romw_en(romw_en), .romo_addr(romo_addr), .romo_en(romo_en),
    .busy(busy), .done(done), .timeout_err(timeout_err), .cur_layer(cur_layer)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a run with mask m; each engine finishes 10 cycles after its start pulse.
  // When stop_layer is reached the task returns with that layer in its first RUN cycle.
  task automatic run_mask(input logic [7:0] m, input int stop_layer);
    logic [7:0] oh;
    layer_en = m;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (m[i]) begin
        oh = 8'd1 << i;
        chk("launch_pulse", lyr_start, oh);
        chk("launch_cur", cur_layer, i[2:0]);
        chk("launch_busy", busy, 1'b1);
        chk("launch_quiet", {ram_en, ram_we, ram_ren, romw_en, romo_en}, 5'd0);
        tick();
        chk("run_no_pulse", lyr_start, 8'd0);
        chk("run_waddr", ram_waddr, waddr_t[i]);
        chk("run_wdata", ram_wdata, wdata_t[i]);
        chk("run_raddr", ram_raddr, raddr_t[i]);
        chk("run_romw", romw_addr, romw_t[i]);
        chk("run_romo", romo_addr, romo_t[i]);
        chk("run_en", {ram_en, ram_we, ram_ren, romw_en, romo_en},
            {lyr_ram_en[i], lyr_ram_we[i], lyr_ram_ren[i], lyr_romw_en[i], lyr_romo_en[i]});
        if (i == stop_layer) return;
        repeat (8) tick();
        lyr_done = oh;
        tick();
        lyr_done = 8'd0;
      end
    end
    chk("end_done", done, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_tmo", timeout_err, 1'b0);
    chk("end_no_pulse", lyr_start, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; layer_en = 8'd0; tmo_limit = 24'd0; lyr_done = 8'd0;
    host_raddr = 16'h0000; host_ren = 1'b0;
    lyr_ram_en  = 8'b1111_1111;
    lyr_ram_we  = 8'b0010_0101;
    lyr_ram_ren = 8'b1000_0100;
    lyr_romw_en = 8'b1110_0000;
    lyr_romo_en = 8'b1010_1111;
    for (int i = 0; i < NL; i++) begin
      waddr_t[i] = 16'hA000 + 16'(i * 16'h0111);
      wdata_t[i] = 8'h30 + 8'(i * 8'h05);
      raddr_t[i] = 16'hB000 + 16'(i * 16'h0203);
      romw_t[i]  = 15'h5500 + 15'(i * 15'h0011);
      romo_t[i]  = 9'h100 + 9'(i * 9'h013);
      lyr_ram_waddr[i*16 +: 16] = waddr_t[i];
      lyr_ram_wdata[i*8 +: 8]   = wdata_t[i];
      lyr_ram_raddr[i*16 +: 16] = raddr_t[i];
      lyr_romw_addr[i*15 +: 15] = romw_t[i];
      lyr_romo_addr[i*9 +: 9]   = romo_t[i];
    end

    // Reset state
    tick();
    chk("rst_outs", {lyr_start, busy, done, timeout_err, cur_layer, ram_en, ram_ren, ram_raddr}, 64'd0);
    rst_n = 1'b1;
    tick();
    host_raddr = 16'h4444;

    // All eight layers in order, then a sparse mask
    run_mask(8'hFF, -1);
    chk("full_last_cur", cur_layer, 3'd7);
    run_mask(8'b1010_0100, -1);
    chk("sparse_last_cur", cur_layer, 3'd7);

    // Empty mask finishes immediately and hands the read port to the host
    layer_en = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_done", done, 1'b1);
    chk("empty_busy", busy, 1'b0);
    chk("empty_no_pulse", lyr_start, 8'd0);
    host_raddr = 16'h0123; host_ren = 1'b1;
    #1;
    chk("host_raddr", ram_raddr, 16'h0123);
    chk("host_ren", ram_ren, 1'b1);
    chk("host_quiet", {ram_en, ram_we, romw_en, romo_en, ram_waddr}, 20'd0);

    // Watchdog expiry after 50 RUN cycles on engine 1
    tmo_limit = 24'd50; layer_en = 8'b0000_0010; start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_launch", lyr_start, 8'b0000_0010);
    chk("wd_clear_done", done, 1'b0);
    repeat (50) tick();
    chk("wd_before", timeout_err, 1'b0);
    chk("wd_before_busy", busy, 1'b1);
    tick();
    chk("wd_tmo", timeout_err, 1'b1);
    chk("wd_tmo_done", done, 1'b0);
    chk("wd_tmo_busy", busy, 1'b0);

    // Completion in the same cycle the watchdog would fire wins
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd2_tmo_cleared", timeout_err, 1'b0);
    repeat (50) tick();
    lyr_done = 8'b0000_0010;
    tick();
    lyr_done = 8'd0;
    chk("wd2_done", done, 1'b1);
    chk("wd2_tmo", timeout_err, 1'b0);
    tmo_limit = 24'd0;

    // Spurious done from another engine and start while busy are ignored
    layer_en = 8'b0001_0100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sp_launch", lyr_start, 8'b0000_0100);
    tick();
    lyr_done = 8'b0001_0000; start = 1'b1; layer_en = 8'hFF;
    tick();
    lyr_done = 8'd0; start = 1'b0;
    chk("sp_cur", cur_layer, 3'd2);
    chk("sp_busy", busy, 1'b1);
    chk("sp_no_pulse", lyr_start, 8'd0);
    repeat (3) tick();
    chk("sp_cur_later", cur_layer, 3'd2);
    lyr_done = 8'b0000_0100;
    tick();
    lyr_done = 8'd0;
    chk("sp_next_launch", lyr_start, 8'b0001_0000);
    tick();
    lyr_done = 8'b0001_0000;
    tick();
    lyr_done = 8'd0;
    chk("sp_done", done, 1'b1);

    // Asynchronous reset while layer 3 is running
    host_ren = 1'b0; host_raddr = 16'h0000;
    run_mask(8'hFF, 3);
    chk("pre_rst_cur", cur_layer, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {lyr_start, busy, done, timeout_err, cur_layer, ram_en, ram_ren, romw_en, romo_en}, 64'd0);
    chk("arst_addrs", {ram_waddr, ram_wdata, ram_raddr, romw_addr}, 64'd0);
    chk("arst_romo", romo_addr, 9'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {busy, done, lyr_start}, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
